// File: rtl/trap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trap_pkg
//  Description : Shared definitions for the trap controller. Holds the
//                sequencer state encoding, the cause-width derivation and the
//                default handler-vector layout.
//  Revision    : 1.0  initial release
// ============================================================================
package trap_pkg;

    // Trap sequencer states. IDLE is zero so that reset and "not busy"
    // share the same encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_VECTOR  = 3'd2,
        ST_HANDLER = 3'd3,
        ST_RETURN  = 3'd4
    } trap_state_e;

    // Width of a cause code able to name every source. A single source still
    // gets a 1-bit cause so that no port collapses to zero width.
    function automatic int unsigned cause_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned c_NSRC_DEF       = 4;
    localparam int unsigned c_PC_W_DEF       = 16;
    localparam int unsigned c_CAUSE_W_DEF    = cause_width(c_NSRC_DEF);
    localparam logic [15:0] c_VEC_BASE_DEF   = 16'h0100;
    localparam int unsigned c_VEC_STRIDE_DEF = 4;

endpackage : trap_pkg
`default_nettype wire

// File: rtl/trap_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : trap_prio_enc
//  Description : Fixed-priority encoder; index 0 has the highest priority.
//                Reports whether any request is set and the lowest set index.
//  Ports       : req_i   [N-1:0]      masked request vector
//                valid_o              at least one request set
//                idx_o   [IDX_W-1:0]  lowest set index (0 when none)
//  Revision    : 1.0  initial release
// ============================================================================
module trap_prio_enc #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule : trap_prio_enc
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl
//  Description : Trap entry/exit sequencer for the program-flow unit.
//                Latches trap requests, picks the highest-priority enabled
//                source, flushes the pipeline, saves return PC and cause,
//                loads the per-cause handler vector and restores the PC on
//                eret.
//  Ports       : rst            async active-high reset
//                clk            rising-edge clock
//                trap_req_i     per-source request pulses
//                trap_en_i      global trap enable
//                pc_cur_i       PC of the instruction being trapped
//                flush_ack_i    pipeline drained
//                eret_i         return-from-trap pulse
//                flush_req_o    pipeline flush request (while in FLUSH)
//                pc_load_o      one-cycle PC load strobe
//                pc_load_val_o  PC value to load (0 when not loading)
//                trap_mode_o    high while the handler runs
//                epc_o          saved return PC
//                cause_o        cause of the current or last trap
//                busy_o         sequencer not idle
//  Revision    : 1.0  initial release
// ============================================================================
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int unsigned    NSRC       = c_NSRC_DEF,
    parameter int unsigned    PC_W       = c_PC_W_DEF,
    // Must equal clog2(NSRC); left as a parameter so the port width is
    // visible to the integrating code.
    parameter int unsigned    CAUSE_W    = cause_width(NSRC),
    parameter logic [PC_W-1:0] VEC_BASE  = PC_W'(c_VEC_BASE_DEF),
    parameter int unsigned    VEC_STRIDE = c_VEC_STRIDE_DEF
) (
    input  logic               rst,
    input  logic               clk,
    input  logic [NSRC-1:0]    trap_req_i,
    input  logic               trap_en_i,
    input  logic [PC_W-1:0]    pc_cur_i,
    input  logic               flush_ack_i,
    input  logic               eret_i,
    output logic               flush_req_o,
    output logic               pc_load_o,
    output logic [PC_W-1:0]    pc_load_val_o,
    output logic               trap_mode_o,
    output logic [PC_W-1:0]    epc_o,
    output logic [CAUSE_W-1:0] cause_o,
    output logic               busy_o
);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    trap_state_e         state_q;
    logic [NSRC-1:0]     pending_q;
    logic [NSRC-1:0]     pending_d;
    logic [PC_W-1:0]     epc_q;
    logic [CAUSE_W-1:0]  cause_q;
    logic                pc_load_q;
    logic [PC_W-1:0]     pc_load_val_q;
    logic                trap_mode_q;

    // ------------------------------------------------------------------
    // Source arbitration
    // ------------------------------------------------------------------
    logic [NSRC-1:0]     w_enabled;
    logic                w_prio_valid;
    logic [CAUSE_W-1:0]  w_prio_idx;
    logic                w_accept;
    logic [NSRC-1:0]     w_clr_mask;
    logic [PC_W-1:0]     w_vec_addr;

    // Disabled traps stay latched in pending_q; they are only hidden from
    // the arbiter.
    assign w_enabled = pending_q & {NSRC{trap_en_i}};

    trap_prio_enc #(
        .N     (NSRC),
        .IDX_W (CAUSE_W)
    ) u_prio_enc (
        .req_i   (w_enabled),
        .valid_o (w_prio_valid),
        .idx_o   (w_prio_idx)
    );

    // Acceptance happens only from IDLE, so there is never nesting and the
    // sequencer spends at least one cycle in IDLE between traps.
    assign w_accept = (state_q == ST_IDLE) && w_prio_valid;

    for (genvar g = 0; g < NSRC; g++) begin : g_clr
        assign w_clr_mask[g] = w_accept && (w_prio_idx == CAUSE_W'(g));
    end

    // New requests are ORed in after the clear so that a request landing on
    // the bit being accepted in the same cycle is not lost.
    assign pending_d = (pending_q & ~w_clr_mask) | trap_req_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Handler vector: base + cause * stride, wrapping in PC_W bits.
    assign w_vec_addr = VEC_BASE + (PC_W'(cause_q) * PC_W'(VEC_STRIDE));

    // ------------------------------------------------------------------
    // Trap sequencer
    // The strobes are registered: they are set on the edge that enters the
    // state in which they must be visible, and default back to zero on
    // every other edge, so pc_load is exactly one cycle wide.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            epc_q         <= '0;
            cause_q       <= '0;
            pc_load_q     <= 1'b0;
            pc_load_val_q <= '0;
            trap_mode_q   <= 1'b0;
        end else begin
            pc_load_q     <= 1'b0;
            pc_load_val_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (w_prio_valid) begin
                        cause_q <= w_prio_idx;
                        epc_q   <= pc_cur_i;
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (flush_ack_i) begin
                        pc_load_q     <= 1'b1;
                        pc_load_val_q <= w_vec_addr;
                        state_q       <= ST_VECTOR;
                    end
                end
                ST_VECTOR: begin
                    trap_mode_q <= 1'b1;
                    state_q     <= ST_HANDLER;
                end
                ST_HANDLER: begin
                    if (eret_i) begin
                        trap_mode_q   <= 1'b0;
                        pc_load_q     <= 1'b1;
                        pc_load_val_q <= epc_q;
                        state_q       <= ST_RETURN;
                    end
                end
                ST_RETURN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    trap_mode_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign flush_req_o   = (state_q == ST_FLUSH);
    assign busy_o        = (state_q != ST_IDLE);
    assign pc_load_o     = pc_load_q;
    assign pc_load_val_o = pc_load_val_q;
    assign trap_mode_o   = trap_mode_q;
    assign epc_o         = epc_q;
    assign cause_o       = cause_q;

endmodule : trap_ctrl
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trap_ctrl
//  Description : Self-checking bench for trap_ctrl. Directed steps in one
//                initial block; every expected PC load is queued when the
//                stimulus that causes it is driven and popped by a monitor
//                when the DUT strobes pc_load.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_trap_ctrl;

    localparam int unsigned c_NSRC = 4;
    localparam int unsigned c_PCW  = 16;
    localparam int unsigned c_CW   = 2;

    logic              rst;
    logic              clk;
    logic [c_NSRC-1:0] trap_req;
    logic              trap_en;
    logic [c_PCW-1:0]  pc_cur;
    logic              flush_ack;
    logic              eret;
    logic              flush_req;
    logic              pc_load;
    logic [c_PCW-1:0]  pc_load_val;
    logic              trap_mode;
    logic [c_PCW-1:0]  epc;
    logic [c_CW-1:0]   cause;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [c_PCW-1:0] exp_q[$];

    trap_ctrl u_dut (
        .rst           (rst),
        .clk           (clk),
        .trap_req_i    (trap_req),
        .trap_en_i     (trap_en),
        .pc_cur_i      (pc_cur),
        .flush_ack_i   (flush_ack),
        .eret_i        (eret),
        .flush_req_o   (flush_req),
        .pc_load_o     (pc_load),
        .pc_load_val_o (pc_load_val),
        .trap_mode_o   (trap_mode),
        .epc_o         (epc),
        .cause_o       (cause),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return busy;
            1:       return pc_load;
            default: return trap_mode;
        endcase
    endfunction

    // Bounded wait for a DUT output to go high; an expired bound is a failure.
    task automatic wait_for(input string tag, input int which, input int max);
        int cnt = 0;
        while (sig(which) !== 1'b1 && cnt < max) begin
            step();
            cnt++;
        end
        chk(tag, 32'(sig(which)), 32'd1);
    endtask

    // Scoreboard side: each pc_load strobe must match the oldest expectation,
    // and pc_load_val must be zero whenever no load is in progress.
    always @(negedge clk) begin
        if (!rst) begin
            if (pc_load === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL pc_load_unexpected: observed load %0h expected no load", pc_load_val);
                end else begin
                    chk("pc_load_val", 32'(pc_load_val), 32'(exp_q.pop_front()));
                end
            end else begin
                chk("pc_load_val_idle", 32'(pc_load_val), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; trap_req = '0; trap_en = 1'b1; pc_cur = '0;
        flush_ack = 1'b1; eret = 1'b0;
        step(3);

        // Reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flush_req", 32'(flush_req), 0);
        chk("rst_pc_load", 32'(pc_load), 0);
        chk("rst_trap_mode", 32'(trap_mode), 0);
        chk("rst_epc", 32'(epc), 0);
        chk("rst_cause", 32'(cause), 0);
        rst = 1'b0;
        step(2);

        // Single trap, exact latency with flush_ack high
        pc_cur = 16'h0042; trap_req = 4'b0100; exp_q.push_back(16'h0108);
        step();                                 // capture edge
        trap_req = '0;
        chk("t1_busy_capture", 32'(busy), 0);
        step();                                 // FLUSH
        chk("t1_busy", 32'(busy), 1);
        chk("t1_flush_req", 32'(flush_req), 1);
        chk("t1_cause", 32'(cause), 2);
        chk("t1_epc", 32'(epc), 16'h0042);
        step();                                 // VECTOR
        chk("t1_pc_load", 32'(pc_load), 1);
        chk("t1_tm_vector", 32'(trap_mode), 0);
        step();                                 // HANDLER
        chk("t1_trap_mode", 32'(trap_mode), 1);
        chk("t1_pc_load_off", 32'(pc_load), 0);
        eret = 1'b1; exp_q.push_back(16'h0042);
        step();                                 // RETURN
        eret = 1'b0;
        chk("t1_ret_load", 32'(pc_load), 1);
        chk("t1_ret_tm", 32'(trap_mode), 0);
        step();                                 // IDLE
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_epc_hold", 32'(epc), 16'h0042);
        chk("t1_cause_hold", 32'(cause), 2);

        // Priority: source 1 wins, source 3 stays pending
        pc_cur = 16'h0150; trap_req = 4'b1010; exp_q.push_back(16'h0104);
        step();
        trap_req = '0;
        step();
        chk("t2_cause1", 32'(cause), 1);
        chk("t2_epc1", 32'(epc), 16'h0150);
        wait_for("t2_tm1", 2, 10);
        eret = 1'b1; exp_q.push_back(16'h0150);
        pc_cur = 16'h0200; flush_ack = 1'b0;
        step();                                 // RETURN
        eret = 1'b0;
        step();                                 // mandatory IDLE cycle
        chk("t2_idle_gap", 32'(busy), 0);
        exp_q.push_back(16'h010C);
        step();
        chk("t2_busy3", 32'(busy), 1);
        chk("t2_cause3", 32'(cause), 3);
        chk("t2_epc3", 32'(epc), 16'h0200);

        // Flush handshake held off for 5 cycles
        for (int i = 0; i < 5; i++) begin
            chk("t3_flush_req", 32'(flush_req), 1);
            chk("t3_no_load", 32'(pc_load), 0);
            step();
        end
        flush_ack = 1'b1;
        step();
        chk("t3_load_after_ack", 32'(pc_load), 1);
        wait_for("t3_tm", 2, 10);
        eret = 1'b1; exp_q.push_back(16'h0200);
        step();
        eret = 1'b0;
        step();

        // Enable gating
        trap_en = 1'b0; trap_req = 4'b0001;
        step();
        trap_req = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_gated_busy", 32'(busy), 0);
        end
        pc_cur = 16'h0300; trap_en = 1'b1; exp_q.push_back(16'h0100);
        step();
        chk("t4_busy", 32'(busy), 1);
        chk("t4_cause", 32'(cause), 0);
        chk("t4_epc", 32'(epc), 16'h0300);
        wait_for("t4_tm", 2, 10);
        eret = 1'b1; exp_q.push_back(16'h0300);
        step();
        eret = 1'b0;
        step();

        // Spurious eret / flush_ack in IDLE, request during HANDLER
        flush_ack = 1'b0; eret = 1'b1;
        step();
        eret = 1'b0; flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;
        step();
        chk("t5_idle_busy", 32'(busy), 0);
        chk("t5_idle_tm", 32'(trap_mode), 0);
        chk("t5_epc_kept", 32'(epc), 16'h0300);
        pc_cur = 16'h0400; trap_req = 4'b0100; exp_q.push_back(16'h0108);
        step();
        trap_req = '0;
        step(3);
        chk("t5_still_flush", 32'(flush_req), 1);
        flush_ack = 1'b1;
        wait_for("t5_tm", 2, 10);
        trap_req = 4'b0001;
        step();
        trap_req = '0;
        chk("t5_tm_held", 32'(trap_mode), 1);
        chk("t5_cause_held", 32'(cause), 2);
        step(2);
        chk("t5_no_nest", 32'(trap_mode), 1);
        eret = 1'b1; exp_q.push_back(16'h0400); exp_q.push_back(16'h0100);
        pc_cur = 16'h0500;
        step();
        eret = 1'b0;
        step();
        chk("t5_gap", 32'(busy), 0);
        step();
        chk("t5_second_cause", 32'(cause), 0);
        chk("t5_second_epc", 32'(epc), 16'h0500);
        wait_for("t5_tm2", 2, 10);
        eret = 1'b1; exp_q.push_back(16'h0500);
        step();
        eret = 1'b0;
        step();

        // Reset in FLUSH with source 3 still pending
        flush_ack = 1'b0; trap_req = 4'b1001;
        step();
        trap_req = '0;
        step();
        chk("t6_in_flush", 32'(flush_req), 1);
        rst = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_flush_req", 32'(flush_req), 0);
        chk("t6_pc_load", 32'(pc_load), 0);
        chk("t6_pc_load_val", 32'(pc_load_val), 0);
        chk("t6_trap_mode", 32'(trap_mode), 0);
        chk("t6_epc", 32'(epc), 0);
        chk("t6_cause", 32'(cause), 0);
        step(2);
        rst = 1'b0; flush_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t6_no_trap", 32'(busy), 0);
        end

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_trap_ctrl
`default_nettype wire

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences entry into and exit from trap mode for the program-flow unit.
- Arbitrates several trap sources by fixed priority, asks the pipeline to flush, saves the return PC and cause, and loads the handler vector.
- Holds trap_mode for the TRAP flag logic. Restores the PC on eret.
- Sits between trap sources (ALU faults, software trap, external), the PC register and the pipeline control.

Parameters:
- NSRC, 4, number of trap sources; index 0 has the highest priority.
- PC_W, 16, PC width.
- CAUSE_W, 2, cause code width; must equal clog2(NSRC).
- VEC_BASE, 16'h0100, handler vector base address.
- VEC_STRIDE, 4, address spacing between per-cause vectors.

Ports:
- rst  in  1  reset first, asynchronous, active-high
- clk  in  1  rising-edge clock
- trap_req  in  NSRC  per-source trap request pulses; one cycle is sufficient
- trap_en  in  1  global trap enable
- pc_cur  in  PC_W  PC of the instruction being trapped
- flush_ack  in  1  pipeline drained
- eret  in  1  return-from-trap pulse
- flush_req  out  1  pipeline flush request
- pc_load  out  1  one-cycle PC load strobe
- pc_load_val  out  PC_W  PC value to load
- trap_mode  out  1  high while the handler runs
- epc  out  PC_W  saved return PC
- cause  out  CAUSE_W  cause of the current or last trap
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: state=IDLE; pending=0; epc=0; cause=0; all strobes and flags 0. Reset mid-operation aborts immediately and clears pending.
- Pending register:
  - pending[i] is set at any edge where trap_req[i]=1.
  - It is cleared only when that source is accepted.
  - If set and clear hit the same bit at the same edge, set wins.
  - Requests arriving during any non-IDLE state stay pending. There is no nesting.
- trap_en=0: pending bits are held but never accepted.
- IDLE: if (pending & {NSRC{trap_en}}) != 0, then at the next edge:
  - cause <= lowest set index;
  - epc <= pc_cur;
  - clear pending[cause];
  - go to FLUSH.
- FLUSH:
  - flush_req=1 (combinational from state).
  - Stays in FLUSH until flush_ack=1 is sampled, then goes to VECTOR.
  - There is no timeout.
- VECTOR:
  - pc_load=1 for exactly one cycle.
  - pc_load_val = VEC_BASE + cause*VEC_STRIDE, truncated to PC_W; wrap is permitted.
  - Next state is HANDLER.
- HANDLER: trap_mode=1. On eret=1, go to RETURN.
- RETURN:
  - pc_load=1 for one cycle with pc_load_val=epc.
  - trap_mode=0; it drops in this cycle.
  - Next state is IDLE.
- IDLE always lasts at least one cycle before re-entry.
- trap_mode is registered: high from the cycle after VECTOR through the last HANDLER cycle.
- Outside VECTOR and RETURN, pc_load_val=0.
- eret is ignored outside HANDLER. flush_ack is ignored outside FLUSH.
- epc and cause hold their values after return until the next accept.
- busy = (state != IDLE).
- Latency with flush_ack tied high: request captured at edge 0; FLUSH from edge 1; pc_load high in the cycle after edge 2; trap_mode high after edge 3.

Decomposition:
- Shared package trap_pkg holds:
  - state encoding: IDLE, FLUSH, VECTOR, HANDLER, RETURN;
  - the CAUSE_W derivation;
  - the VEC_BASE and VEC_STRIDE defaults.
- One sub-module, trap_prio_enc: parameterised lowest-index priority encoder.
  - Inputs: pending & enable mask.
  - Outputs: valid and index.

Test Plan:
- Single trap: flush_ack=1, pc_cur=16'h0042, trap_req=4'b0100 for one cycle.
  - Required: cause=2, epc=16'h0042.
  - pc_load for one cycle with pc_load_val=16'h0108; trap_mode=1.
  - eret pulse gives pc_load with value 16'h0042, trap_mode=0, busy=0.
- Priority and pending: trap_req=4'b1010 in the same cycle.
  - Required: cause=1 first and pending[3] retained.
  - After eret and one IDLE cycle, a second trap runs with cause=3 and vector 16'h010C.
- Flush handshake: flush_ack held 0 for 5 cycles.
  - Required: flush_req stays 1 and pc_load stays 0 for those 5 cycles.
  - flush_ack=1 gives pc_load in the following cycle.
- Enable gating: trap_en=0 with trap_req[0] pulsed.
  - Required: busy stays 0 for 10 cycles.
  - Raising trap_en starts the trap with cause=0 and vector 16'h0100.
- Spurious controls: eret and flush_ack pulsed while in IDLE, and a second trap_req[0] pulse during HANDLER.
  - Required: the stray eret and flush_ack have no effect.
  - The HANDLER-time request is taken only after return.
- Reset mid-trap: assert rst while in FLUSH, with pending[3]=1.
  - Required: all outputs 0 immediately (asynchronous), pending cleared, and no trap after rst is released.
